// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Lookup is purely combinational on the registered entry. Training from EX
// lands at the next edge. inv_all clears every valid bit and takes priority
// over a same-cycle update.
// Optional build macro: PRED_BYPASS_EN. When it is defined, a lookup that hits
// the entry being trained this cycle sees the post-update valid/ctr/target.
module branch_predictor #(
  parameter int         INDEX_BITS = 6,
  parameter logic [1:0] CTR_ALLOC  = 2'b10,
  parameter logic [1:0] CTR_RESET  = 2'b01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] lookup_PC,
  output logic        BTB_hit,
  output logic        is_branch_predict,
  output logic [31:0] BTB_PC,
  input  logic        upd_valid,
  input  logic [31:0] upd_PC,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        inv_all
);

  localparam int ENTRIES  = 1 << INDEX_BITS;
  localparam int TAG_BITS = 30 - INDEX_BITS;

  logic [ENTRIES-1:0]      valid_q, valid_d;
  logic [ENTRIES-1:0][1:0] ctr_q, ctr_d;
  logic [TAG_BITS-1:0]     tag_q [ENTRIES];
  logic [31:0]             tgt_q [ENTRIES];

  logic [INDEX_BITS-1:0] upd_idx, lk_idx;
  logic [TAG_BITS-1:0]   upd_tag, lk_tag;
  logic                  upd_hit;
  logic                  wr_en;
  logic [1:0]            new_ctr;
  logic [31:0]           new_tgt;

  logic                  lk_valid;
  logic [TAG_BITS-1:0]   lk_tag_q;
  logic [1:0]            lk_ctr;
  logic [31:0]           lk_tgt;

  // Byte-offset bits of both PCs carry no information for a 4-byte aligned ISA.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{lookup_PC[1:0], upd_PC[1:0]};

  assign upd_idx = upd_PC[INDEX_BITS+1:2];
  assign upd_tag = upd_PC[31:INDEX_BITS+2];
  assign lk_idx  = lookup_PC[INDEX_BITS+1:2];
  assign lk_tag  = lookup_PC[31:INDEX_BITS+2];

  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
  // A not-taken miss allocates nothing, so it writes nothing.
  assign wr_en   = upd_valid && !inv_all && (upd_hit || upd_taken);
  assign new_tgt = upd_taken ? upd_target : tgt_q[upd_idx];

  // Trained counter value: saturating step on a hit, allocation value on a miss.
  always_comb begin
    new_ctr = CTR_ALLOC;
    if (upd_hit) begin
      if (upd_taken) begin
        new_ctr = (ctr_q[upd_idx] == 2'b11) ? 2'b11 : ctr_q[upd_idx] + 2'd1;
      end else begin
        new_ctr = (ctr_q[upd_idx] == 2'b00) ? 2'b00 : ctr_q[upd_idx] - 2'd1;
      end
    end
  end

  // Next-state for the resettable valid and counter vectors.
  always_comb begin
    valid_d = valid_q;
    ctr_d   = ctr_q;
    if (inv_all) begin
      valid_d = '0;
    end else if (wr_en) begin
      valid_d[upd_idx] = 1'b1;
      ctr_d[upd_idx]   = new_ctr;
    end
  end

  // Valid bits and counters, asynchronously reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      ctr_q   <= {ENTRIES{CTR_RESET}};
    end else begin
      valid_q <= valid_d;
      ctr_q   <= ctr_d;
    end
  end

  // Tag and target storage; contents are meaningless until the valid bit is set.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[upd_idx] <= upd_tag;
      tgt_q[upd_idx] <= new_tgt;
    end
  end

  // Entry read for the lookup port, optionally forwarding this cycle's write.
  always_comb begin
    lk_valid = valid_q[lk_idx];
    lk_tag_q = tag_q[lk_idx];
    lk_ctr   = ctr_q[lk_idx];
    lk_tgt   = tgt_q[lk_idx];
`ifdef PRED_BYPASS_EN
    // Forwarding is held off while reset is asserted so outputs read as empty.
    if (rst && wr_en && (upd_idx == lk_idx) && (upd_tag == lk_tag)) begin
      lk_valid = 1'b1;
      lk_tag_q = upd_tag;
      lk_ctr   = new_ctr;
      lk_tgt   = new_tgt;
    end
`endif
  end

  // Prediction outputs; target reads as zero on a miss.
  always_comb begin
    BTB_hit           = lk_valid && (lk_tag_q == lk_tag);
    is_branch_predict = BTB_hit && lk_ctr[1];
    BTB_PC            = BTB_hit ? lk_tgt : 32'h0;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
Direct-mapped branch target buffer with 2-bit saturating direction counters. It sits directly upstream of the fetch stage. Each cycle it answers fetch's lookup_PC with a hit flag, a taken prediction and a target PC. It is trained by branch resolutions from EX and can be bulk-invalidated (e.g. on fence.i).

Parameters:
INDEX_BITS, 6, log2 of entry count (64 entries); index = PC[INDEX_BITS+1:2], tag = PC[31:INDEX_BITS+2]
CTR_ALLOC, 2'b10, counter value written when a new entry is allocated (weakly taken)
CTR_RESET, 2'b01, counter value of every entry after reset (weakly not-taken)

Ports:
clk  input  1  clock
rst  input  1  asynchronous reset, active-low
lookup_PC  input  32  PC for which fetch requests a prediction
BTB_hit  output  1  entry at lookup index is valid and its tag matches
is_branch_predict  output  1  BTB_hit && counter[1]
BTB_PC  output  32  stored target on hit; 32'h0 on miss
upd_valid  input  1  EX resolved a control-flow instruction this cycle
upd_PC  input  32  PC of the resolved instruction
upd_taken  input  1  actual direction
upd_target  input  32  actual target (meaningful when upd_taken=1)
inv_all  input  1  clear all valid bits at next edge

Behaviour:
- Storage per entry: valid (1), tag (32-INDEX_BITS-2), target (32), ctr (2). Target and tag arrays need no reset; valid and ctr are reset.
- Reset (rst=0, async, also mid-operation): all valid=0, all ctr=CTR_RESET. Outputs are therefore BTB_hit=0, is_branch_predict=0, BTB_PC=0.
- Lookup is combinational, zero latency. Fetch consumes the outputs in the same cycle it drives lookup_PC. lookup_PC[1:0] is ignored.
- Lookup sees pre-edge state: an update written at edge N is first visible to lookups during cycle N+1.
- Update at posedge when upd_valid=1 (upd_PC[1:0] ignored):
  - Hit, taken: ctr = min(ctr+1, 3); target = upd_target.
  - Hit, not taken: ctr = max(ctr-1, 0); target is unchanged.
  - Miss, taken: allocate and overwrite the slot (aliased entries are evicted). Sets valid=1, tag, target=upd_target, ctr=CTR_ALLOC.
  - Miss, not taken: no change (no allocation).
- inv_all=1: every valid bit is cleared at the next edge; ctr and target are unchanged. If upd_valid is asserted in the same cycle, inv_all wins and the update is dropped entirely.
- Counter arithmetic is 2-bit saturating with no wrap: 11 plus taken stays 11, 00 plus not-taken stays 00.
- No stall input: updates are accepted every cycle, and back-to-back updates to the same index apply sequentially per edge.

Optional Feature:
PRED_BYPASS_EN
- Defined: when upd_valid=1, inv_all=0 and upd index/tag equal the lookup index/tag, the lookup outputs reflect the post-update entry in the same cycle. This means a combinational forward of the computed next valid/ctr/target.
- Undefined: no forwarding; lookups always see registered state.

Test Plan:
1. Release reset, lookup_PC=0x0001_0000 -> BTB_hit=0, is_branch_predict=0, BTB_PC=0x0000_0000.
2. upd_valid=1, upd_PC=0x0001_0010, upd_taken=1, upd_target=0x0001_0040. Next cycle lookup 0x0001_0010 -> BTB_hit=1, is_branch_predict=1, BTB_PC=0x0001_0040.
3. From state of test 2, counter walk:
   - Two not-taken updates -> ctr 10→01→00; lookup gives hit=1, predict=0, BTB_PC still 0x0001_0040.
   - Four taken updates with target 0x0001_0080 -> ctr 01,10,11,11 (saturates); predict=1, BTB_PC=0x0001_0080.
4. Aliasing (INDEX_BITS=6, both at index 4):
   - Entry 0x0001_0010 is valid; lookup 0x0001_0110 -> hit=0.
   - Taken update 0x0001_0110 with target 0x0001_0200 -> lookup 0x0001_0110 hit, BTB_PC=0x0001_0200; lookup 0x0001_0010 -> hit=0.
   - Not-taken update to a missing PC 0x0001_0020 -> lookup still misses.
5. With several valid entries, assert inv_all=1 together with a taken update for 0x0001_0030. Next cycle all lookups, including 0x0001_0030, -> hit=0. Assert rst low mid-run -> outputs drop to 0 immediately, with no clock edge required.
6. Same-cycle taken update and lookup of fresh PC 0x0001_0050:
   - Without PRED_BYPASS_EN: hit=0 that cycle, hit=1 the next.
   - With PRED_BYPASS_EN: hit=1, predict=1, BTB_PC=upd_target in the same cycle.
